// File: rtl/custom_busmatrix_pkg.sv
// Shared AHB encodings for the bus-matrix input stages and output arbiters.
package custom_busmatrix_pkg;

    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    localparam logic [2:0] BUR_SINGLE = 3'b000;
    localparam logic [2:0] BUR_INCR   = 3'b001;
    localparam logic [2:0] BUR_WRAP4  = 3'b010;
    localparam logic [2:0] BUR_INCR4  = 3'b011;
    localparam logic [2:0] BUR_WRAP8  = 3'b100;
    localparam logic [2:0] BUR_INCR8  = 3'b101;
    localparam logic [2:0] BUR_WRAP16 = 3'b110;
    localparam logic [2:0] BUR_INCR16 = 3'b111;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // NONSEQ and SEQ both carry a real transfer
    function automatic logic trn_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/custom_bm_addr_hold_reg.sv
// Load-enabled copy of one AHB address phase, plus the live/held output mux.
module custom_bm_addr_hold_reg
    import custom_busmatrix_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              use_held,
    input  logic              sel_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        trans_i,
    input  logic              write_i,
    input  logic [2:0]        size_i,
    input  logic [2:0]        burst_i,
    input  logic [3:0]        prot_i,
    input  logic              lock_i,
    output logic              sel_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        trans_o,
    output logic              write_o,
    output logic [2:0]        size_o,
    output logic [2:0]        burst_o,
    output logic [3:0]        prot_o,
    output logic              lock_o
);

    logic              sel_q,   sel_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [1:0]        trans_q, trans_d;
    logic              write_q, write_d;
    logic [2:0]        size_q,  size_d;
    logic [2:0]        burst_q, burst_d;
    logic [3:0]        prot_q,  prot_d;
    logic              lock_q,  lock_d;

    always_comb begin
        sel_d   = sel_q;
        addr_d  = addr_q;
        trans_d = trans_q;
        write_d = write_q;
        size_d  = size_q;
        burst_d = burst_q;
        prot_d  = prot_q;
        lock_d  = lock_q;
        if (load) begin
            sel_d   = sel_i;
            addr_d  = addr_i;
            trans_d = trans_i;
            write_d = write_i;
            size_d  = size_i;
            burst_d = burst_i;
            prot_d  = prot_i;
            lock_d  = lock_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 1'b0;
            addr_q  <= '0;
            trans_q <= TRN_IDLE;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            burst_q <= BUR_SINGLE;
            prot_q  <= 4'b0000;
            lock_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            trans_q <= trans_d;
            write_q <= write_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            prot_q  <= prot_d;
            lock_q  <= lock_d;
        end
    end

    assign sel_o   = use_held ? sel_q   : sel_i;
    assign addr_o  = use_held ? addr_q  : addr_i;
    assign trans_o = use_held ? trans_q : trans_i;
    assign write_o = use_held ? write_q : write_i;
    assign size_o  = use_held ? size_q  : size_i;
    assign burst_o = use_held ? burst_q : burst_i;
    assign prot_o  = use_held ? prot_q  : prot_i;
    assign lock_o  = use_held ? lock_q  : lock_i;

endmodule

// File: rtl/custom_bm_input_stage.sv
// Master-port front end of the bus matrix: holds address phases until an
// output arbiter accepts them and returns data-phase ready/response.
module custom_bm_input_stage
    import custom_busmatrix_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_trans,
    input  logic              readyout_m,
    input  logic              hresp_m,
    output logic              trans_pending,
    output logic              held_tran,
    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic              HREADYOUTS,
    output logic              HRESPS
);

    logic load_reg;
    logic accept;
    logic reg_hold_q, reg_hold_d;
    logic data_phase_q, data_phase_d;

    assign load_reg      = HSELS & HREADYS & trn_active(HTRANSS);
    assign trans_pending = load_reg | reg_hold_q;
    assign accept        = trans_pending & active_trans & readyout_m;
    assign held_tran     = reg_hold_q;

    always_comb begin
        reg_hold_d = reg_hold_q;
        if (load_reg && !active_trans) begin
            reg_hold_d = 1'b1;
        end else if (active_trans && readyout_m) begin
            reg_hold_d = 1'b0;
        end
    end

    // a wait state on the owning output keeps the data phase open
    always_comb begin
        data_phase_d = data_phase_q;
        if (accept) begin
            data_phase_d = 1'b1;
        end else if (readyout_m) begin
            data_phase_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            reg_hold_q   <= 1'b0;
            data_phase_q <= 1'b0;
        end else begin
            reg_hold_q   <= reg_hold_d;
            data_phase_q <= data_phase_d;
        end
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = RESP_OKAY;
        if (reg_hold_q) begin
            HREADYOUTS = 1'b0;
        end else if (data_phase_q) begin
            HREADYOUTS = readyout_m;
        end
        if (data_phase_q) begin
            HRESPS = hresp_m;
        end
    end

    custom_bm_addr_hold_reg #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .load     (load_reg & ~active_trans),
        .use_held (reg_hold_q),
        .sel_i    (HSELS),
        .addr_i   (HADDRS),
        .trans_i  (HTRANSS),
        .write_i  (HWRITES),
        .size_i   (HSIZES),
        .burst_i  (HBURSTS),
        .prot_i   (HPROTS),
        .lock_i   (HMASTLOCKS),
        .sel_o    (HSELM),
        .addr_o   (HADDRM),
        .trans_o  (HTRANSM),
        .write_o  (HWRITEM),
        .size_o   (HSIZEM),
        .burst_o  (HBURSTM),
        .prot_o   (HPROTM),
        .lock_o   (HMASTLOCKM)
    );

endmodule

// File: tb/tb_custom_bm_input_stage.sv
// Scoreboard bench for custom_bm_input_stage: each stimulus cycle queues its
// expected outputs, a negedge monitor pops and compares them.
module tb_custom_bm_input_stage;
    import custom_busmatrix_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        active_trans;
    logic        readyout_m;
    logic        hresp_m;
    logic        trans_pending;
    logic        held_tran;
    logic        HSELM;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic        HMASTLOCKM;
    logic        HREADYOUTS;
    logic        HRESPS;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic        rdy;
        logic        resp;
        logic        tp;
        logic        held;
        logic        chk_a;
        logic [31:0] addr;
        logic        lock;
    } exp_t;

    exp_t sb[$];

    always #5 HCLK = ~HCLK;

    custom_bm_input_stage #(
        .ADDR_W (32)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .HSELS         (HSELS),
        .HADDRS        (HADDRS),
        .HTRANSS       (HTRANSS),
        .HWRITES       (HWRITES),
        .HSIZES        (HSIZES),
        .HBURSTS       (HBURSTS),
        .HPROTS        (HPROTS),
        .HMASTLOCKS    (HMASTLOCKS),
        .HREADYS       (HREADYS),
        .active_trans  (active_trans),
        .readyout_m    (readyout_m),
        .hresp_m       (hresp_m),
        .trans_pending (trans_pending),
        .held_tran     (held_tran),
        .HSELM         (HSELM),
        .HADDRM        (HADDRM),
        .HTRANSM       (HTRANSM),
        .HWRITEM       (HWRITEM),
        .HSIZEM        (HSIZEM),
        .HBURSTM       (HBURSTM),
        .HPROTM        (HPROTM),
        .HMASTLOCKM    (HMASTLOCKM),
        .HREADYOUTS    (HREADYOUTS),
        .HRESPS        (HRESPS)
    );

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
        end
    endtask

    always @(negedge HCLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "HREADYOUTS", {31'd0, HREADYOUTS}, {31'd0, e.rdy});
            chk(e.name, "HRESPS", {31'd0, HRESPS}, {31'd0, e.resp});
            chk(e.name, "trans_pending", {31'd0, trans_pending}, {31'd0, e.tp});
            chk(e.name, "held_tran", {31'd0, held_tran}, {31'd0, e.held});
            if (e.chk_a) begin
                chk(e.name, "HADDRM", HADDRM, e.addr);
                chk(e.name, "HMASTLOCKM", {31'd0, HMASTLOCKM}, {31'd0, e.lock});
            end
        end
    end

    task automatic drive(input logic sel, input logic [1:0] tr,
                         input logic [31:0] a, input logic lk, input logic hr,
                         input logic act, input logic rm, input logic rsp);
        HSELS        = sel;
        HTRANSS      = tr;
        HADDRS       = a;
        HMASTLOCKS   = lk;
        HREADYS      = hr;
        active_trans = act;
        readyout_m   = rm;
        hresp_m      = rsp;
    endtask

    task automatic push(input string nm, input logic rdy, input logic resp,
                        input logic tp, input logic held, input logic ca,
                        input logic [31:0] ea, input logic el);
        exp_t e;
        e.name  = nm;
        e.rdy   = rdy;
        e.resp  = resp;
        e.tp    = tp;
        e.held  = held;
        e.chk_a = ca;
        e.addr  = ea;
        e.lock  = el;
        sb.push_back(e);
    endtask

    // Inputs: sel trans addr lock hreadys act rdy_m hresp
    // Expect: hreadyouts hresps trans_pending held chk_addr addr lock
    task automatic cyc(input string nm, input logic sel, input logic [1:0] tr,
                       input logic [31:0] a, input logic lk, input logic hr,
                       input logic act, input logic rm, input logic rsp,
                       input logic e_rdy, input logic e_resp, input logic e_tp,
                       input logic e_held, input logic e_ca,
                       input logic [31:0] e_a, input logic e_lk);
        drive(sel, tr, a, lk, hr, act, rm, rsp);
        push(nm, e_rdy, e_resp, e_tp, e_held, e_ca, e_a, e_lk);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HWRITES = 1'b1;
        HSIZES  = 3'b010;
        HBURSTS = BUR_SINGLE;
        HPROTS  = 4'b0011;
        HRESETn = 1'b0;
        drive(1'b0, TRN_IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge HCLK);
        #1;
        push("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // granted immediately: pass straight through, then a data phase
        cyc("t1_addr",  1, TRN_NONSEQ, 32'h1000, 0, 1, 1, 1, 0,  1, 0, 1, 0, 1, 32'h1000, 0);
        cyc("t1_dwait", 1, TRN_IDLE,   32'h0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0, 0);
        cyc("t1_ddone", 1, TRN_IDLE,   32'h0,    0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0, 0);

        // output busy 3 cycles: address held while HADDRS moves
        cyc("t2_load",  1, TRN_NONSEQ, 32'h2000, 1, 1, 0, 1, 0,  1, 0, 1, 0, 1, 32'h2000, 1);
        cyc("t2_hold1", 1, TRN_IDLE,   32'h3333, 0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 32'h2000, 1);
        cyc("t2_hold2", 1, TRN_IDLE,   32'h4444, 0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 32'h2000, 1);
        cyc("t2_grant", 1, TRN_IDLE,   32'h5555, 0, 0, 1, 1, 0,  0, 0, 1, 1, 1, 32'h2000, 1);
        cyc("t2_data",  1, TRN_IDLE,   32'h5555, 0, 1, 0, 1, 0,  1, 0, 0, 0, 1, 32'h5555, 0);

        // INCR4 with two wait states on beat 2
        HBURSTS = BUR_INCR4;
        cyc("t3_b1",   1, TRN_NONSEQ, 32'h100, 0, 1, 1, 1, 0,  1, 0, 1, 0, 1, 32'h100, 0);
        cyc("t3_b2",   1, TRN_SEQ,    32'h104, 0, 1, 1, 1, 0,  1, 0, 1, 0, 1, 32'h104, 0);
        cyc("t3_w1",   1, TRN_SEQ,    32'h108, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 32'h108, 0);
        cyc("t3_w2",   1, TRN_SEQ,    32'h108, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 32'h108, 0);
        cyc("t3_b3",   1, TRN_SEQ,    32'h108, 0, 1, 1, 1, 0,  1, 0, 1, 0, 1, 32'h108, 0);
        cyc("t3_b4",   1, TRN_SEQ,    32'h10C, 0, 1, 1, 1, 0,  1, 0, 1, 0, 1, 32'h10C, 0);
        cyc("t3_last", 1, TRN_IDLE,   32'h0,   0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0, 0);
        HBURSTS = BUR_SINGLE;

        // two-cycle ERROR, master cancels with IDLE, then reloads normally
        cyc("t4_addr",   1, TRN_NONSEQ, 32'h300, 0, 1, 1, 1, 0,  1, 0, 1, 0, 1, 32'h300, 0);
        cyc("t4_err1",   1, TRN_NONSEQ, 32'h304, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 32'h0, 0);
        cyc("t4_err2",   1, TRN_IDLE,   32'h304, 0, 1, 0, 1, 1,  1, 1, 0, 0, 0, 32'h0, 0);
        cyc("t4_idle",   1, TRN_IDLE,   32'h0,   0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0, 0);
        cyc("t4_reload", 1, TRN_NONSEQ, 32'h400, 0, 1, 0, 1, 0,  1, 0, 1, 0, 1, 32'h400, 0);
        cyc("t4_held",   1, TRN_IDLE,   32'h0,   0, 0, 1, 1, 0,  0, 0, 1, 1, 1, 32'h400, 0);
        cyc("t4_data",   1, TRN_IDLE,   32'h0,   0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0, 0);

        // IDLE/BUSY selected and NONSEQ unselected: local OKAY, no request
        cyc("t5_idle",  1, TRN_IDLE,   32'h500, 0, 1, 0, 1, 1,  1, 0, 0, 0, 1, 32'h500, 0);
        cyc("t5_busy",  1, TRN_BUSY,   32'h500, 0, 1, 0, 1, 1,  1, 0, 0, 0, 1, 32'h500, 0);
        cyc("t5_unsel", 0, TRN_NONSEQ, 32'h504, 0, 1, 0, 1, 0,  1, 0, 0, 0, 1, 32'h504, 0);

        // async reset while a transfer is held
        cyc("t6_load", 1, TRN_NONSEQ, 32'h600, 1, 1, 0, 1, 0,  1, 0, 1, 0, 1, 32'h600, 1);
        cyc("t6_held", 1, TRN_IDLE,   32'h0,   0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 32'h600, 1);
        drive(1'b1, TRN_IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        HRESETn = 1'b0;
        #1;
        chk("t6_async", "held_tran", {31'd0, held_tran}, 32'd0);
        chk("t6_async", "HREADYOUTS", {31'd0, HREADYOUTS}, 32'd1);
        chk("t6_async", "trans_pending", {31'd0, trans_pending}, 32'd0);
        chk("t6_async", "HADDRM", HADDRM, 32'h0);
        push("t6_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cyc("t6_after", 1, TRN_IDLE, 32'h0, 0, 1, 0, 1, 0,  1, 0, 0, 0, 1, 32'h0, 0);

        @(negedge HCLK);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
